// File: rtl/bru_pkg.sv
// Shared types for the ID-stage branch resolver: branch op encoding and FSM states.
package bru_pkg;

   typedef enum logic [3:0] {
      BR_NONE = 4'd0,
      BEQ     = 4'd1,
      BNE     = 4'd2,
      BLT     = 4'd3,
      BGE     = 4'd4,
      BLTU    = 4'd5,
      BGEU    = 4'd6,
      B       = 4'd7,
      BL      = 4'd8,
      JIRL    = 4'd9
   } br_op_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      DRAIN    = 2'd2
   } state_e;

   // Codes 10-15 are not branches and behave exactly like BR_NONE.
   function automatic logic is_branch(input logic [3:0] op);
      return (op >= BEQ) && (op <= JIRL);
   endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch condition and target evaluation for one ID instruction.
module br_cond_eval
   import bru_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] rj_i,
   input  logic [31:0] rd_i,
   input  logic [31:0] offs_i,
   output logic        taken_o,
   output logic [31:0] target_o
);

   always_comb begin
      target_o = (op_i == JIRL) ? rj_i + offs_i : pc_i + offs_i;
      case (op_i)
         BEQ:         taken_o = (rj_i == rd_i);
         BNE:         taken_o = (rj_i != rd_i);
         BLT:         taken_o = ($signed(rj_i) < $signed(rd_i));
         BGE:         taken_o = ($signed(rj_i) >= $signed(rd_i));
         BLTU:        taken_o = (rj_i < rd_i);
         BGEU:        taken_o = (rj_i >= rd_i);
         B, BL, JIRL: taken_o = 1'b1;
         default:     taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolver.sv
// ID-stage branch resolution: predictor update, mispredict redirect handshake and
// branch/mispredict performance counters.
module branch_resolver
   import bru_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             id_valid_i,
   input  logic [31:0]      id_pc_i,
   input  logic [3:0]       id_br_op_i,
   input  logic [31:0]      id_rj_i,
   input  logic [31:0]      id_rd_i,
   input  logic [31:0]      id_offs_i,
   input  logic             id_pred_taken_i,
   input  logic [31:0]      id_pred_target_i,
   output logic             id_stall_o,
   output logic             bp_update_valid_o,
   output logic             bp_update_isJumpInst_o,
   output logic [31:0]      bp_update_pc_o,
   output logic [31:0]      bp_update_targetPc_o,
   output logic             bp_update_taken_o,
   output logic             redirect_valid_o,
   output logic [31:0]      redirect_pc_o,
   input  logic             redirect_ready_i,
   output logic             if_flush_o,
   output logic [CNT_W-1:0] perf_br_cnt_o,
   output logic [CNT_W-1:0] perf_miss_cnt_o
);

   state_e             state_q;
   logic               upd_valid_q, upd_jump_q, upd_taken_q;
   logic [31:0]        upd_pc_q, upd_target_q, redirect_pc_q;
   logic [CNT_W-1:0]   br_cnt_q, miss_cnt_q;

   logic               taken, is_br, accept, mispredict;
   logic [31:0]        target, next_pc;

   br_cond_eval u_cond (
      .op_i     (id_br_op_i),
      .pc_i     (id_pc_i),
      .rj_i     (id_rj_i),
      .rd_i     (id_rd_i),
      .offs_i   (id_offs_i),
      .taken_o  (taken),
      .target_o (target)
   );

   always_comb begin
      is_br      = is_branch(id_br_op_i);
      accept     = id_valid_i && (state_q == IDLE);
      next_pc    = taken ? target : id_pc_i + 32'd4;
      // A non-branch never resolves taken, so pred_taken alone flags it.
      mispredict = (id_pred_taken_i != taken) ||
                   (is_br && id_pred_taken_i && taken && (id_pred_target_i != target));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         upd_valid_q   <= 1'b0;
         upd_jump_q    <= 1'b0;
         upd_taken_q   <= 1'b0;
         upd_pc_q      <= RESET_PC;
         upd_target_q  <= 32'd0;
         redirect_pc_q <= 32'd0;
         br_cnt_q      <= '0;
         miss_cnt_q    <= '0;
      end else begin
         upd_valid_q <= accept;
         upd_jump_q  <= accept && is_br;
         if (accept) begin
            upd_pc_q     <= id_pc_i;
            upd_target_q <= target;
            upd_taken_q  <= taken;
            if (is_br)      br_cnt_q   <= br_cnt_q + CNT_W'(1'b1);
            if (mispredict) miss_cnt_q <= miss_cnt_q + CNT_W'(1'b1);
         end
         case (state_q)
            IDLE: begin
               if (accept && mispredict) begin
                  redirect_pc_q <= next_pc;
                  state_q       <= REDIRECT;
               end
            end
            REDIRECT: if (redirect_ready_i) state_q <= DRAIN;
            DRAIN:    state_q <= IDLE;
            default:  state_q <= IDLE;
         endcase
      end
   end

   assign id_stall_o             = (state_q == REDIRECT);
   assign redirect_valid_o       = (state_q == REDIRECT);
   assign if_flush_o             = (state_q == REDIRECT) && redirect_ready_i;
   assign redirect_pc_o          = redirect_pc_q;
   assign bp_update_valid_o      = upd_valid_q;
   assign bp_update_isJumpInst_o = upd_jump_q;
   assign bp_update_pc_o         = upd_pc_q;
   assign bp_update_targetPc_o   = upd_target_q;
   assign bp_update_taken_o      = upd_taken_q;
   assign perf_br_cnt_o          = br_cnt_q;
   assign perf_miss_cnt_o        = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: a table of correctly predicted ops plus
// hand-written mispredict, redirect-hold/reset and counter-wrap sequences.
module tb_branch_resolver;
   import bru_pkg::*;

   localparam int unsigned CW = 4;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          id_valid_i;
   logic [31:0]   id_pc_i, id_rj_i, id_rd_i, id_offs_i, id_pred_target_i;
   logic [3:0]    id_br_op_i;
   logic          id_pred_taken_i;
   logic          id_stall_o, bp_update_valid_o, bp_update_isJumpInst_o, bp_update_taken_o;
   logic [31:0]   bp_update_pc_o, bp_update_targetPc_o, redirect_pc_o;
   logic          redirect_valid_o, redirect_ready_i, if_flush_o;
   logic [CW-1:0] perf_br_cnt_o, perf_miss_cnt_o;

   int n_cmp = 0;
   int n_fail = 0;

   branch_resolver #(.RESET_PC(32'h8000_0000), .CNT_W(CW)) dut (
      .clk_i                  (clk_i),
      .rst_i                  (rst_i),
      .id_valid_i             (id_valid_i),
      .id_pc_i                (id_pc_i),
      .id_br_op_i             (id_br_op_i),
      .id_rj_i                (id_rj_i),
      .id_rd_i                (id_rd_i),
      .id_offs_i              (id_offs_i),
      .id_pred_taken_i        (id_pred_taken_i),
      .id_pred_target_i       (id_pred_target_i),
      .id_stall_o             (id_stall_o),
      .bp_update_valid_o      (bp_update_valid_o),
      .bp_update_isJumpInst_o (bp_update_isJumpInst_o),
      .bp_update_pc_o         (bp_update_pc_o),
      .bp_update_targetPc_o   (bp_update_targetPc_o),
      .bp_update_taken_o      (bp_update_taken_o),
      .redirect_valid_o       (redirect_valid_o),
      .redirect_pc_o          (redirect_pc_o),
      .redirect_ready_i       (redirect_ready_i),
      .if_flush_o             (if_flush_o),
      .perf_br_cnt_o          (perf_br_cnt_o),
      .perf_miss_cnt_o        (perf_miss_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] pc, rj, rd, offs;
      logic        exp_jump, exp_taken;
      logic [31:0] exp_tgt;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(input logic [3:0] op, input logic [31:0] pc, rj, rd, offs,
                               input logic jmp, tkn, input logic [31:0] tgt);
      vec_t v;
      v.op = op; v.pc = pc; v.rj = rj; v.rd = rd; v.offs = offs;
      v.exp_jump = jmp; v.exp_taken = tkn; v.exp_tgt = tgt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] pc, rj, rd, offs,
                        input logic pt, input logic [31:0] ptgt);
      id_valid_i = 1'b1; id_br_op_i = op; id_pc_i = pc; id_rj_i = rj; id_rd_i = rd;
      id_offs_i = offs; id_pred_taken_i = pt; id_pred_target_i = ptgt;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".upd_valid"}, {31'd0, bp_update_valid_o}, 32'd0);
      chk({tag, ".upd_jump"}, {31'd0, bp_update_isJumpInst_o}, 32'd0);
      chk({tag, ".upd_taken"}, {31'd0, bp_update_taken_o}, 32'd0);
      chk({tag, ".upd_pc"}, bp_update_pc_o, 32'h8000_0000);
      chk({tag, ".upd_tgt"}, bp_update_targetPc_o, 32'd0);
      chk({tag, ".redir_valid"}, {31'd0, redirect_valid_o}, 32'd0);
      chk({tag, ".redir_pc"}, redirect_pc_o, 32'd0);
      chk({tag, ".stall"}, {31'd0, id_stall_o}, 32'd0);
      chk({tag, ".flush"}, {31'd0, if_flush_o}, 32'd0);
      chk({tag, ".br_cnt"}, 32'(perf_br_cnt_o), 32'd0);
      chk({tag, ".miss_cnt"}, 32'(perf_miss_cnt_o), 32'd0);
   endtask

   initial begin
      vecs[0]  = mk(BEQ,   32'h8000_0010, 32'd5, 32'd5, 32'h20, 1, 1, 32'h8000_0030);
      vecs[1]  = mk(BNE,   32'h8000_0020, 32'd1, 32'd2, 32'h10, 1, 1, 32'h8000_0030);
      vecs[2]  = mk(BLT,   32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'h8, 1, 1, 32'h8000_0008);
      vecs[3]  = mk(BLTU,  32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'h8, 1, 0, 32'h8000_0008);
      vecs[4]  = mk(BGE,   32'h8000_0100, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1, 1,
                    32'h8000_00F0);
      vecs[5]  = mk(BGEU,  32'h8000_0100, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1, 0,
                    32'h8000_00F0);
      vecs[6]  = mk(B,     32'h8000_0200, 32'd0, 32'd0, 32'h100, 1, 1, 32'h8000_0300);
      vecs[7]  = mk(BL,    32'hFFFF_FFF0, 32'd0, 32'd0, 32'h20, 1, 1, 32'h0000_0010);
      vecs[8]  = mk(JIRL,  32'h8000_0400, 32'h8000_1000, 32'd0, 32'h8, 1, 1, 32'h8000_1008);
      vecs[9]  = mk(BR_NONE, 32'h8000_0500, 32'd0, 32'd0, 32'd0, 0, 0, 32'd0);
      vecs[10] = mk(4'd12, 32'h8000_0600, 32'd3, 32'd3, 32'd0, 0, 0, 32'd0);
      vecs[11] = mk(BEQ,   32'h8000_0700, 32'd3, 32'd4, 32'h40, 1, 0, 32'h8000_0740);

      rst_i = 1'b1; redirect_ready_i = 1'b0;
      id_valid_i = 1'b0; id_br_op_i = '0; id_pc_i = '0; id_rj_i = '0; id_rd_i = '0;
      id_offs_i = '0; id_pred_taken_i = 1'b0; id_pred_target_i = '0;
      step();
      step();
      chk_reset("rst");
      rst_i = 1'b0;

      // Correctly predicted ops, back to back; prediction equals the expected result.
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].op, vecs[i].pc, vecs[i].rj, vecs[i].rd, vecs[i].offs,
               vecs[i].exp_taken, vecs[i].exp_tgt);
         step();
         chk($sformatf("v%0d.valid", i), {31'd0, bp_update_valid_o}, 32'd1);
         chk($sformatf("v%0d.jump", i), {31'd0, bp_update_isJumpInst_o},
             {31'd0, vecs[i].exp_jump});
         chk($sformatf("v%0d.taken", i), {31'd0, bp_update_taken_o},
             {31'd0, vecs[i].exp_taken});
         chk($sformatf("v%0d.pc", i), bp_update_pc_o, vecs[i].pc);
         if (vecs[i].exp_jump)
            chk($sformatf("v%0d.tgt", i), bp_update_targetPc_o, vecs[i].exp_tgt);
         chk($sformatf("v%0d.redir", i), {31'd0, redirect_valid_o}, 32'd0);
      end
      chk("tbl.br_cnt", 32'(perf_br_cnt_o), 32'd10);
      chk("tbl.miss_cnt", 32'(perf_miss_cnt_o), 32'd0);

      // Direction mispredict with a delayed handshake.
      drive(BNE, 32'h8000_0040, 32'd7, 32'd7, 32'h10, 1'b1, 32'h8000_0050);
      step();
      chk("dir.redir_valid", {31'd0, redirect_valid_o}, 32'd1);
      chk("dir.redir_pc", redirect_pc_o, 32'h8000_0044);
      chk("dir.stall", {31'd0, id_stall_o}, 32'd1);
      chk("dir.upd_valid", {31'd0, bp_update_valid_o}, 32'd1);
      chk("dir.taken", {31'd0, bp_update_taken_o}, 32'd0);
      chk("dir.miss_cnt", 32'(perf_miss_cnt_o), 32'd1);
      chk("dir.br_cnt", 32'(perf_br_cnt_o), 32'd11);
      drive(BEQ, 32'h8000_0050, 32'd1, 32'd1, 32'h4, 1'b1, 32'h8000_0054);
      step();
      chk("dir.hold_noupd", {31'd0, bp_update_valid_o}, 32'd0);
      chk("dir.hold_stall", {31'd0, id_stall_o}, 32'd1);
      chk("dir.hold_pc", redirect_pc_o, 32'h8000_0044);
      redirect_ready_i = 1'b1;
      #1;
      chk("dir.flush", {31'd0, if_flush_o}, 32'd1);
      step();
      chk("drain.stall", {31'd0, id_stall_o}, 32'd0);
      chk("drain.redir", {31'd0, redirect_valid_o}, 32'd0);
      chk("drain.flush", {31'd0, if_flush_o}, 32'd0);
      chk("drain.noupd", {31'd0, bp_update_valid_o}, 32'd0);
      redirect_ready_i = 1'b0;
      step();
      chk("drain.dropped", {31'd0, bp_update_valid_o}, 32'd0);
      chk("drain.br_cnt", 32'(perf_br_cnt_o), 32'd11);
      id_valid_i = 1'b0;

      // Target mispredict, fetch ready in the first REDIRECT cycle.
      drive(JIRL, 32'h8000_0400, 32'h8000_1000, 32'd0, 32'h8, 1'b1, 32'h8000_2000);
      redirect_ready_i = 1'b1;
      step();
      id_valid_i = 1'b0;
      chk("tgt.redir_pc", redirect_pc_o, 32'h8000_1008);
      chk("tgt.redir_valid", {31'd0, redirect_valid_o}, 32'd1);
      chk("tgt.taken", {31'd0, bp_update_taken_o}, 32'd1);
      chk("tgt.target", bp_update_targetPc_o, 32'h8000_1008);
      chk("tgt.flush", {31'd0, if_flush_o}, 32'd1);
      chk("tgt.miss_cnt", 32'(perf_miss_cnt_o), 32'd2);
      step();
      chk("tgt.drain_redir", {31'd0, redirect_valid_o}, 32'd0);
      redirect_ready_i = 1'b0;
      step();

      // False taken on a non-branch, then reset while the redirect is pending.
      drive(BR_NONE, 32'h8000_0100, 32'd0, 32'd0, 32'd0, 1'b1, 32'h8000_0200);
      step();
      id_valid_i = 1'b0;
      chk("nb.jump", {31'd0, bp_update_isJumpInst_o}, 32'd0);
      chk("nb.upd_valid", {31'd0, bp_update_valid_o}, 32'd1);
      chk("nb.redir_pc", redirect_pc_o, 32'h8000_0104);
      chk("nb.br_cnt", 32'(perf_br_cnt_o), 32'd12);
      chk("nb.miss_cnt", 32'(perf_miss_cnt_o), 32'd3);
      for (int c = 1; c <= 2; c++) begin
         step();
         chk($sformatf("hold%0d.pc", c), redirect_pc_o, 32'h8000_0104);
         chk($sformatf("hold%0d.stall", c), {31'd0, id_stall_o}, 32'd1);
         chk($sformatf("hold%0d.noupd", c), {31'd0, bp_update_valid_o}, 32'd0);
      end
      rst_i = 1'b1;
      step();
      chk_reset("hold_rst");
      rst_i = 1'b0;
      step();
      chk("post_rst.redir", {31'd0, redirect_valid_o}, 32'd0);

      // Counter wrap with 16 back-to-back correctly predicted branches.
      for (int i = 0; i < 16; i++) begin
         drive(B, 32'h8000_0000 + 32'(i * 4), 32'd0, 32'd0, 32'h40, 1'b1,
               32'h8000_0040 + 32'(i * 4));
         step();
         chk($sformatf("wrap%0d.valid", i), {31'd0, bp_update_valid_o}, 32'd1);
         if (i == 14) chk("wrap.cnt15", 32'(perf_br_cnt_o), 32'd15);
      end
      id_valid_i = 1'b0;
      chk("wrap.cnt0", 32'(perf_br_cnt_o), 32'd0);
      chk("wrap.miss0", 32'(perf_miss_cnt_o), 32'd0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
